// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of the single SDRAM controller port (CPU data bus = port 0, DMA = port 1).
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction owned; picks a winner when any req is high
// BUSY    | command latched and ctl_req held until the controller acks
// RELEASE | pN_ack high for this one cycle; requester drops req
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  input  logic [DATA_WIDTH/8-1:0] p0_nwr,
  output logic                    p0_ack,
  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_nwr,
  output logic                    p1_ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ctl_req,
  output logic                    ctl_we,
  output logic [ADDR_WIDTH-1:0]   ctl_addr,
  output logic [DATA_WIDTH-1:0]   ctl_wdata,
  output logic [DATA_WIDTH/8-1:0] ctl_nwr,
  input  logic                    ctl_ack,
  input  logic [DATA_WIDTH-1:0]   ctl_rdata,
  output logic                    grant
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic                   last_grant, last_grant_nxt;
  logic                   grant_nxt;
  logic                   ctl_req_nxt;
  logic                   ctl_we_nxt;
  logic [ADDR_WIDTH-1:0]  ctl_addr_nxt;
  logic [DATA_WIDTH-1:0]  ctl_wdata_nxt;
  logic [MASK_WIDTH-1:0]  ctl_nwr_nxt;
  logic [DATA_WIDTH-1:0]  rdata_nxt;
  logic                   p0_ack_nxt;
  logic                   p1_ack_nxt;
  logic                   tie;
  logic                   winner;

  assign tie = p0_req & p1_req;

  // winner is only meaningful when at least one req is high
  always_comb begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    winner = tie ? ~last_grant : ~p0_req;
`else
    winner = ~p0_req;
`endif
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_nxt      = grant;
    ctl_req_nxt    = ctl_req;
    ctl_we_nxt     = ctl_we;
    ctl_addr_nxt   = ctl_addr;
    ctl_wdata_nxt  = ctl_wdata;
    ctl_nwr_nxt    = ctl_nwr;
    rdata_nxt      = rdata;
    p0_ack_nxt     = 1'b0;
    p1_ack_nxt     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (p0_req || p1_req) begin
          ctl_we_nxt    = winner ? p1_we    : p0_we;
          ctl_addr_nxt  = winner ? p1_addr  : p0_addr;
          ctl_wdata_nxt = winner ? p1_wdata : p0_wdata;
          ctl_nwr_nxt   = winner ? p1_nwr   : p0_nwr;
          ctl_req_nxt   = 1'b1;
          grant_nxt     = winner;
          state_nxt     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // a dropped req does not abort: only the controller ends the transaction
        if (ctl_ack) begin
          ctl_req_nxt    = 1'b0;
          rdata_nxt      = ctl_rdata;
          p0_ack_nxt     = ~grant;
          p1_ack_nxt     = grant;
          last_grant_nxt = grant;
          state_nxt      = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      ctl_req    <= 1'b0;
      ctl_we     <= 1'b0;
      ctl_addr   <= '0;
      ctl_wdata  <= '0;
      ctl_nwr    <= '0;
      rdata      <= '0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant      <= grant_nxt;
      ctl_req    <= ctl_req_nxt;
      ctl_we     <= ctl_we_nxt;
      ctl_addr   <= ctl_addr_nxt;
      ctl_wdata  <= ctl_wdata_nxt;
      ctl_nwr    <= ctl_nwr_nxt;
      rdata      <= rdata_nxt;
      p0_ack     <= p0_ack_nxt;
      p1_ack     <= p1_ack_nxt;
    end
  end

endmodule
